// File: rtl/s3g_uart_rx_if.sv
// Byte/strobe link between the S3G UART receiver and its consumer (packet parser or bench).
// master = receiver side, slave = consumer side that also drives the serial line.
interface s3g_uart_rx_if;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        input  rxd,
        output rx_data,
        output rx_done,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        output rxd,
        input  rx_data,
        input  rx_done,
        input  rx_frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/s3g_uart_rx.sv
// 8N1 oversampling UART receiver feeding the S3G packet parser.
// Optional UART_RX_FILTER_EN adds a 3-sample majority filter on the synchronised line.
module s3g_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic          clk,
    input  logic          rst,
    s3g_uart_rx_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_t;

    state_t           state;
    logic [1:0]       sync;
    logic             rxd_s;
    logic             rxd_f;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       data_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;

    // Two-flop synchroniser; idles high so reset does not look like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= 2'b11;
        else      sync <= {sync[0], bus.rxd};
    end
    assign rxd_s = sync[1];

`ifdef UART_RX_FILTER_EN
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist <= 3'b111;
        else      hist <= {hist[1:0], rxd_s};
    end
    assign rxd_f = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign rxd_f = rxd_s;
`endif

    // Frame recovery: every decision is taken at the mid-point of a bit cell
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxd_f) begin
                        cnt    <= CNT_HALF;
                        state  <= S_START;
                        busy_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rxd_f) begin
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxd_f, shreg[7:1]};
                        cnt   <= CNT_FULL;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == '0) begin
                        if (rxd_f) begin
                            data_q <= shreg;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WAIT_HI: begin
                    // A break or stuck-low line must release before a new start is armed
                    if (rxd_f) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_done      = done_q;
    assign bus.rx_frame_err = err_q;
    assign bus.rx_busy      = busy_q;

endmodule
